ddr5_ca_cmd_encoder: RTL and testbench



---
 rtl/ddr5_ca_cmd_encoder.sv | 107 ++++++++++
 tb/tb_ddr5_ca_cmd_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_ca_cmd_encoder.sv
// ddr5_ca_cmd_encoder: DDR5 CA-bus command encoder with tRCD/tRP/tRFC gating and bank tracking; optional ca_par output under DDR5_CA_PARITY_EN
module ddr5_ca_cmd_encoder #(
  parameter int T_RCD = 4,
  parameter int T_RP  = 3,
  parameter int T_RFC = 8
) (
  input  logic        ck_t,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [2:0]  req_bank,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cs_n,
  output logic [13:0] ca,
`ifdef DDR5_CA_PARITY_EN
  output logic        ca_par,
`endif
  output logic        err,
  output logic [7:0]  bank_open
);
  localparam int TMAX = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP) : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [2:0] OP_ACT = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2, OP_PRE = 3'd3, OP_REF = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CMD1, S_CMD2} state_t;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_op, r_bank, w_op, w_bank;
  logic [15:0]   r_row;
  logic [9:0]    r_col;
  logic [8:0]    w_row_lo;
  logic [TW-1:0] r_trcd, r_trp, r_trfc;
  logic          w_idle, w_acc, w_legal, w_gate, w_issue, w_two;
  logic [13:0]   w_c1, w_c2, w_ca_nxt;
  assign req_ready = (r_state == S_IDLE);
  // decode the live request (IDLE) or the captured one (WAIT/CMD), check legality and timing, pick next bus word and state
  always_comb begin
    w_idle   = r_state == S_IDLE;
    w_acc    = w_idle & req_valid;
    w_op     = w_idle ? req_op : r_op;
    w_bank   = w_idle ? req_bank : r_bank;
    w_row_lo = w_idle ? req_row[8:0] : r_row[8:0];
    w_legal  = (req_op == OP_ACT) ? !bank_open[req_bank] :
               (req_op == OP_RD || req_op == OP_WR) ? bank_open[req_bank] :
               (req_op == OP_PRE) ? 1'b1 :
               (req_op == OP_REF) ? (bank_open == 8'h00) : 1'b0;
    w_gate   = (r_trfc == '0) & ((w_op == OP_ACT || w_op == OP_REF) ? (r_trp == '0) :
               (w_op == OP_RD || w_op == OP_WR) ? (r_trcd == '0) : 1'b1);
    w_issue  = ((w_acc & w_legal) | (r_state == S_WAIT)) & w_gate;
    w_two    = r_op == OP_ACT || r_op == OP_RD || r_op == OP_WR;
    w_c1     = (w_op == OP_ACT) ? {w_row_lo, w_bank, 2'b00} :
               (w_op == OP_RD)  ? {6'd0, w_bank, 5'b11101} :
               (w_op == OP_WR)  ? {6'd0, w_bank, 5'b01101} :
               (w_op == OP_PRE) ? {6'd0, w_bank, 5'b11011} : 14'b00000000010011;
    w_c2     = (r_op == OP_ACT) ? {7'd0, r_row[15:9]} : {4'd0, r_col};
    w_ca_nxt = w_issue ? w_c1 : (r_state == S_CMD1 && w_two) ? w_c2 : 14'd0;
    w_state_nxt = w_issue ? S_CMD1 :
                  (w_acc & w_legal) ? S_WAIT :
                  (r_state == S_WAIT) ? S_WAIT :
                  (r_state == S_CMD1 && w_two) ? S_CMD2 : S_IDLE;
  end
  // state, captured request, registered CA bus, error pulse and per-bank open flags
  always_ff @(posedge ck_t or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_bank    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      cs_n      <= 1'b1;
      ca        <= '0;
      err       <= 1'b0;
      bank_open <= '0;
`ifdef DDR5_CA_PARITY_EN
      ca_par    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_op   <= req_op;
        r_bank <= req_bank;
        r_row  <= req_row;
        r_col  <= req_col;
      end
      cs_n <= !w_issue;
      ca   <= w_ca_nxt;
      err  <= w_acc & !w_legal;
      if (w_issue && w_op == OP_ACT) bank_open[w_bank] <= 1'b1;
      if (w_issue && w_op == OP_PRE) bank_open[w_bank] <= 1'b0;
`ifdef DDR5_CA_PARITY_EN
      ca_par <= ^w_ca_nxt;
`endif
    end
  end
  // spacing timers load T-1 on the issuing edge so the dependent command issues exactly T edges later
  always_ff @(posedge ck_t or negedge rst_n) begin
    if (!rst_n) begin
      r_trcd <= '0;
      r_trp  <= '0;
      r_trfc <= '0;
    end else begin
      r_trcd <= (w_issue && w_op == OP_ACT) ? TW'(T_RCD - 1) : (r_trcd != '0) ? r_trcd - 1'b1 : r_trcd;
      r_trp  <= (w_issue && w_op == OP_PRE) ? TW'(T_RP - 1)  : (r_trp  != '0) ? r_trp  - 1'b1 : r_trp;
      r_trfc <= (w_issue && w_op == OP_REF) ? TW'(T_RFC - 1) : (r_trfc != '0) ? r_trfc - 1'b1 : r_trfc;
    end
  end
endmodule

// File: tb/tb_ddr5_ca_cmd_encoder.sv
// tb_ddr5_ca_cmd_encoder: scoreboard bench with a timestamp-based reference model of the CA command encoder
module tb_ddr5_ca_cmd_encoder;
  localparam int T_RCD = 4, T_RP = 3, T_RFC = 8;
  logic        ck_t = 1'b0, rst_n, req_valid, req_ready, cs_n, err;
  logic [2:0]  req_op, req_bank;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic [13:0] ca;
  logic [7:0]  bank_open;
`ifdef DDR5_CA_PARITY_EN
  logic        ca_par;
`endif
  typedef struct {
    longint      cyc;
    bit          is_err;
    logic [13:0] c1;
    bit          two;
    logic [13:0] c2;
    logic [7:0]  bo;
  } exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0, checks = 0;
  longint      cyc = 0;
  bit          sb_off = 0, pend = 0;
  logic [13:0] pend_ca;
  logic [7:0]  m_bo;
  longint      lact, lpre, lref;
  int          rv, wn;
  logic [2:0]  rop;

  ddr5_ca_cmd_encoder #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
    .ck_t(ck_t), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .cs_n(cs_n), .ca(ca),
`ifdef DDR5_CA_PARITY_EN
    .ca_par(ca_par),
`endif
    .err(err), .bank_open(bank_open)
  );

  always #5 ck_t = ~ck_t;
  always @(posedge ck_t) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_bo = 8'h00;
    lact = -1000;
    lpre = -1000;
    lref = -1000;
  endtask

  // Called at a negedge; presents one request once the DUT is ready and records the expected response.
  task automatic send(input logic [2:0] op, input logic [2:0] b, input logic [15:0] row, input logic [9:0] col);
    int     n, ri, bi;
    longint a, i;
    bit     legal;
    exp_t   e;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge ck_t);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", req_ready, 1);
      return;
    end
    req_valid = 1'b1;
    req_op = op;
    req_bank = b;
    req_row = row;
    req_col = col;
    a = cyc + 1;
    ri = int'(row);
    bi = int'(b);
    legal = (op == 0) ? !m_bo[b] : (op == 1 || op == 2) ? m_bo[b] : (op == 3) ? 1'b1 : (op == 4) ? (m_bo == 0) : 1'b0;
    e.is_err = !legal;
    e.two = 0;
    e.c1 = 0;
    e.c2 = 0;
    if (!legal) e.cyc = a;
    else begin
      i = a;
      if ((op == 0 || op == 4) && lpre + T_RP > i) i = lpre + T_RP;
      if ((op == 1 || op == 2) && lact + T_RCD > i) i = lact + T_RCD;
      if (lref + T_RFC > i) i = lref + T_RFC;
      e.cyc = i;
      case (op)
        3'd0: begin e.c1 = 14'((ri % 512) * 32 + bi * 4); e.two = 1; e.c2 = 14'(ri / 512); lact = i; m_bo[b] = 1'b1; end
        3'd1: begin e.c1 = 14'(29 + bi * 32); e.two = 1; e.c2 = 14'(col); end
        3'd2: begin e.c1 = 14'(13 + bi * 32); e.two = 1; e.c2 = 14'(col); end
        3'd3: begin e.c1 = 14'(27 + bi * 32); lpre = i; m_bo[b] = 1'b0; end
        default: begin e.c1 = 14'd19; lref = i; end
      endcase
    end
    e.bo = m_bo;
    sbq.push_back(e);
    @(negedge ck_t);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || pend) && n < 100) begin
      @(negedge ck_t);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (2) @(negedge ck_t);
  endtask

  // Monitor: every DUT output event pops the oldest expectation; quiet cycles must show an idle bus.
  always @(negedge ck_t) begin
    if (!rst_n || sb_off) pend = 0;
    else if (pend) begin
      chk("cmd2_cs_n", cs_n, 1);
      chk("cmd2_ca", ca, pend_ca);
      pend = 0;
    end else if (!cs_n || err) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: cs_n=%0b err=%0b ca=%0h (cycle %0d)", cs_n, err, ca, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("err", err, mon_e.is_err);
        chk("cmd1_cs_n", cs_n, mon_e.is_err);
        chk("cmd1_ca", ca, mon_e.is_err ? 14'd0 : mon_e.c1);
        chk("bank_open", bank_open, mon_e.bo);
        if (mon_e.is_err) chk("ready_on_err", req_ready, 1);
`ifdef DDR5_CA_PARITY_EN
        chk("ca_par", ca_par, ^(mon_e.is_err ? 14'd0 : mon_e.c1));
`endif
        pend = !mon_e.is_err && mon_e.two;
        pend_ca = mon_e.c2;
      end
    end else begin
      chk("idle_ca", ca, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 0;
    req_bank = 0;
    req_row = 0;
    req_col = 0;
    model_reset();
    repeat (3) @(negedge ck_t);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_ca", ca, 0);
    chk("rst_err", err, 0);
    chk("rst_bank_open", bank_open, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge ck_t);
    send(3'd0, 3'd2, 16'h1234, 10'd0);
    send(3'd1, 3'd2, 16'd0, 10'h155);
    send(3'd3, 3'd2, 16'd0, 10'd0);
    send(3'd0, 3'd2, 16'($urandom), 10'd0);
    send(3'd1, 3'd5, 16'd0, 10'd0);
    send(3'd7, 3'd0, 16'd0, 10'd0);
    send(3'd3, 3'd2, 16'd0, 10'd0);
    send(3'd4, 3'd0, 16'd0, 10'd0);
    send(3'd0, 3'd0, 16'hBEEF, 10'd0);
    send(3'd0, 3'd1, 16'h0F0F, 10'd0);
    send(3'd4, 3'd0, 16'd0, 10'd0);
    drain();
    sb_off = 1;
    send(3'd2, 3'd1, 16'd0, 10'h2AA);
    wn = 0;
    while (cs_n && wn < 32) begin
      @(negedge ck_t);
      wn++;
    end
    chk("wr_cmd1_seen", cs_n, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_ca", ca, 0);
    chk("mid_rst_bank_open", bank_open, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", req_ready, 1);
    req_valid = 1'b1;
    req_op = 3'd0;
    req_bank = 3'd3;
    repeat (2) @(negedge ck_t);
    req_valid = 1'b0;
    rst_n = 1'b1;
    sbq.delete();
    model_reset();
    repeat (4) begin
      @(negedge ck_t);
      chk("post_rst_cs_n", cs_n, 1);
      chk("post_rst_ca", ca, 0);
      chk("post_rst_bank_open", bank_open, 0);
    end
    sb_off = 0;
    for (int k = 0; k < 250; k++) begin
      rv = $urandom_range(0, 9);
      rop = (rv < 3) ? 3'd0 : (rv < 5) ? 3'd1 : (rv == 5) ? 3'd2 : (rv < 8) ? 3'd3 : (rv == 8) ? 3'd4 : 3'($urandom_range(5, 7));
      repeat ($urandom_range(0, 2)) @(negedge ck_t);
      send(rop, 3'($urandom_range(0, (k % 4 == 0) ? 7 : 3)), 16'($urandom), 10'($urandom));
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
